// File: rtl/spi_slave_mw_if.sv
// spi_slave_mw_if: word-side receive/transmit handshake bundle of spi_slave_mw.
interface spi_slave_mw_if #(
   parameter int BITS = 8
);
   logic [BITS-1:0] rx_data;
   logic            rx_valid;
   logic [BITS-1:0] tx_data;
   logic            tx_valid;
   logic            tx_ready;
   logic            tx_underrun;
   logic            frame_err;
   logic            busy;
   modport slave (
      output rx_data, rx_valid, tx_ready, tx_underrun, frame_err, busy,
      input  tx_data, tx_valid
   );
   modport master (
      input  rx_data, rx_valid, tx_ready, tx_underrun, frame_err, busy,
      output tx_data, tx_valid
   );
endinterface

// File: rtl/spi_slave_mw.sv
// spi_slave_mw: oversampled SPI slave, any CPOL/CPHA, multi-word frames; SPI_SLAVE_LSB_FIRST_EN selects LSB-first shifting.
module spi_slave_mw #(
   parameter int BITS        = 8,
   parameter int CPOL        = 0,
   parameter int CPHA        = 0,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sck,
   input  logic          mosi,
   input  logic          csn,
   output logic          miso,
   spi_slave_mw_if.slave bus
);
   localparam int CW = $clog2(BITS);
   localparam logic [CW-1:0] LAST = CW'(BITS - 1);
   typedef enum logic [1:0] {IDLE, ACTIVE, LOCKOUT} state_t;
   state_t state, state_nx;
   logic [SYNC_STAGES-1:0] sck_s, mosi_s, csn_s;
   logic sck_d, csn_d, sck_now, csn_now, mosi_now;
   logic sck_rise, sck_fall, sample, shift, csn_fall, csn_rise;
   logic act, frame_end, load, accept, full, tx_bit;
   logic [CW-1:0] cnt;
   logic [BITS-1:0] tx_sh, rx_sh, hold, tx_next, rx_next;
   always_ff @(posedge clk) begin
      sck_s  <= {sck_s[SYNC_STAGES-2:0], sck};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], mosi};
      csn_s  <= {csn_s[SYNC_STAGES-2:0], csn};
      sck_d  <= sck_now;
      csn_d  <= csn_now;
   end
   assign sck_now   = sck_s[SYNC_STAGES-1];
   assign csn_now   = csn_s[SYNC_STAGES-1];
   assign mosi_now  = mosi_s[SYNC_STAGES-1];
   assign sck_rise  = sck_now & ~sck_d;
   assign sck_fall  = ~sck_now & sck_d;
   assign csn_fall  = csn_d & ~csn_now;
   assign csn_rise  = ~csn_d & csn_now;
   assign sample    = (CPOL == CPHA) ? sck_rise : sck_fall;
   assign shift     = (CPOL == CPHA) ? sck_fall : sck_rise;
   assign frame_end = state == ACTIVE && csn_rise;
   // a CSN rise outranks any SCK edge detected in the same cycle
   assign act       = state == ACTIVE && !csn_rise;
   assign load      = (CPHA == 0 && state == IDLE && csn_fall) || (act && shift && cnt == '0);
   assign accept    = bus.tx_valid && !full;
`ifdef SPI_SLAVE_LSB_FIRST_EN
   assign tx_bit  = tx_sh[0];
   assign tx_next = {1'b0, tx_sh[BITS-1:1]};
   assign rx_next = {mosi_now, rx_sh[BITS-1:1]};
`else
   assign tx_bit  = tx_sh[BITS-1];
   assign tx_next = {tx_sh[BITS-2:0], 1'b0};
   assign rx_next = {rx_sh[BITS-2:0], mosi_now};
`endif
   assign miso         = state == ACTIVE ? tx_bit : 1'bz;
   assign bus.busy     = state == ACTIVE;
   assign bus.tx_ready = !full;
   always_ff @(posedge clk) state <= rst ? LOCKOUT : state_nx;
   always_comb begin
      state_nx = state;
      if (state == IDLE && csn_fall) state_nx = ACTIVE;
      else if (frame_end) state_nx = IDLE;
      else if (state == LOCKOUT && csn_now) state_nx = IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt             <= '0;
         tx_sh           <= '0;
         rx_sh           <= '0;
         hold            <= '0;
         full            <= 1'b0;
         bus.rx_data     <= '0;
         bus.rx_valid    <= 1'b0;
         bus.tx_underrun <= 1'b0;
         bus.frame_err   <= 1'b0;
      end else begin
         bus.rx_valid    <= act && sample && cnt == LAST;
         bus.tx_underrun <= load && !full;
         bus.frame_err   <= frame_end && cnt != '0;
         full            <= accept || (full && !load);
         if (accept) hold <= bus.tx_data;
         if (frame_end) begin
            cnt   <= '0;
            tx_sh <= '0;
            rx_sh <= '0;
         end else begin
            if (load) tx_sh <= full ? hold : '0;
            else if (act && shift) tx_sh <= tx_next;
            if (act && sample) begin
               rx_sh <= rx_next;
               cnt   <= cnt == LAST ? '0 : cnt + CW'(1);
               if (cnt == LAST) bus.rx_data <= rx_next;
            end
         end
      end
   end
endmodule
